// File: rtl/nsp_pkg.sv
// Shared types and elaboration helpers for the neural stream packer.
package nsp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DROP,
        ST_DRAIN,
        ST_EOF
    } nsp_state_e;

    function automatic int nsp_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic bit nsp_pack_legal(input int pack);
        return (pack == 1) || (pack == 2) || (pack == 4);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
module sync_fifo_ram
    import nsp_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 1024,
    localparam int AW    = nsp_clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read-before-write: a read and write to the same address return the old word.
    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/neural_stream_packer.sv
// Packs SPI sample words into wide FIFO words for a host reader, with
// frame-level drop on overflow and a stop/drain/EOF sequence.
module neural_stream_packer
    import nsp_pkg::*;
#(
    parameter int  IN_W  = 16,
    parameter int  PACK  = 2,
    parameter int  DEPTH = 1024,
    localparam int OUT_W = IN_W * PACK,
    localparam int AW    = nsp_clog2(DEPTH)
) (
    input  logic             bus_clk,
    input  logic             reset_n,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_wen,
    input  logic             in_sof,
    input  logic             stop,
    input  logic             rd_open,
    input  logic             rd_rden,
    output logic [OUT_W-1:0] rd_data,
    output logic             rd_empty,
    output logic             rd_eof,
    output logic             overflow,
    output logic [15:0]      drop_count,
    output logic [AW:0]      fill_level
);

    if (!nsp_pack_legal(PACK)) begin : g_bad_pack
        $error("neural_stream_packer: PACK must be 1, 2 or 4");
    end

    localparam int              SLOT_W     = (PACK > 1) ? nsp_clog2(PACK) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(PACK - 1);
    localparam logic [AW:0]     FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [1:0]        rst_sync_q;
    logic              rst_n_i;
    nsp_state_e        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [OUT_W-1:0]  pack_q, pack_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       fill_q, fill_d;
    logic              ovf_q, ovf_d;
    logic [15:0]       drop_q, drop_d;

    logic              pop, space, push, accept, do_drop;
    logic [OUT_W-1:0]  push_data, accept_base, merged;
    logic [SLOT_W-1:0] accept_slot;

    // Assertion is immediate; release is delayed two clocks to avoid metastability.
    always_ff @(posedge bus_clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_i = rst_sync_q[1];

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        pack_d      = pack_q;
        ovf_d       = ovf_q;
        drop_d      = drop_q;
        push        = 1'b0;
        push_data   = pack_q;
        accept      = 1'b0;
        accept_slot = slot_q;
        accept_base = pack_q;
        do_drop     = 1'b0;
        merged      = '0;
        pop         = rd_rden && (fill_q != '0);
        space       = (fill_q != FULL_LEVEL) || pop;

        case (state_q)
            ST_IDLE: begin
                if (rd_open && in_wen && in_sof) begin
                    state_d     = ST_RUN;
                    accept      = 1'b1;
                    accept_slot = '0;
                    accept_base = '0;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DRAIN;
                    slot_d  = '0;
                    pack_d  = '0;
                    push    = (slot_q != '0) && space;
                end else if (in_wen) begin
                    if (in_sof && (slot_q != '0)) begin
                        // Unused upper slots of pack_q are already zero, so it is the padded word.
                        if (space) begin
                            push        = 1'b1;
                            accept      = 1'b1;
                            accept_slot = '0;
                            accept_base = '0;
                        end else begin
                            do_drop = 1'b1;
                        end
                    end else begin
                        accept = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (stop) begin
                    state_d = ST_DRAIN;
                end else if (in_wen && in_sof) begin
                    if (space) begin
                        state_d     = ST_RUN;
                        accept      = 1'b1;
                        accept_slot = '0;
                        accept_base = '0;
                    end else begin
                        do_drop = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (fill_q == '0) state_d = ST_EOF;
            end
            default: ;
        endcase

        if (accept) begin
            merged = accept_base;
            for (int i = 0; i < PACK; i++) begin
                if (accept_slot == SLOT_W'(i)) merged[i*IN_W +: IN_W] = in_data;
            end
            if (accept_slot == LAST_SLOT) begin
                if (space) begin
                    push      = 1'b1;
                    push_data = merged;
                    pack_d    = '0;
                    slot_d    = '0;
                end else begin
                    do_drop = 1'b1;
                end
            end else begin
                pack_d = merged;
                slot_d = accept_slot + 1'b1;
            end
        end

        if (do_drop) begin
            state_d = ST_DROP;
            pack_d  = '0;
            slot_d  = '0;
            ovf_d   = 1'b1;
            if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fill_d   = fill_q;
        if (push && !pop)      fill_d = fill_q + 1'b1;
        else if (!push && pop) fill_d = fill_q - 1'b1;

        // Host closing the device flushes everything except the drop statistic.
        if (!rd_open) begin
            state_d  = ST_IDLE;
            pack_d   = '0;
            slot_d   = '0;
            ovf_d    = 1'b0;
            push     = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end
    end

    always_ff @(posedge bus_clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            slot_q   <= '0;
            pack_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            pack_q   <= pack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    sync_fifo_ram #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (bus_clk),
        .rst_n (rst_n_i),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (push_data),
        .re    (pop),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign rd_empty   = (fill_q == '0);
    assign rd_eof     = (state_q == ST_EOF);
    assign overflow   = ovf_q;
    assign drop_count = drop_q;
    assign fill_level = fill_q;

endmodule

// File: tb/tb_neural_stream_packer.sv
// Scoreboard bench: instance A (PACK=2, DEPTH=4) and instance B (PACK=4, DEPTH=8).
module tb_neural_stream_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic [15:0] a_in_data;
    logic        a_in_wen, a_in_sof, a_stop, a_rd_open, a_rd_rden;
    logic [31:0] a_rd_data;
    logic        a_rd_empty, a_rd_eof, a_overflow;
    logic [15:0] a_drop_count;
    logic [2:0]  a_fill_level;

    logic [15:0] b_in_data;
    logic        b_in_wen, b_in_sof, b_stop, b_rd_open, b_rd_rden;
    logic [63:0] b_rd_data;
    logic        b_rd_empty, b_rd_eof, b_overflow;
    logic [15:0] b_drop_count;
    logic [3:0]  b_fill_level;

    int checks = 0;
    int failures = 0;
    logic [31:0] qa[$];
    logic [63:0] qb[$];

    neural_stream_packer #(.IN_W(16), .PACK(2), .DEPTH(4)) u_dut_a (
        .bus_clk(clk), .reset_n(reset_n), .in_data(a_in_data), .in_wen(a_in_wen),
        .in_sof(a_in_sof), .stop(a_stop), .rd_open(a_rd_open), .rd_rden(a_rd_rden),
        .rd_data(a_rd_data), .rd_empty(a_rd_empty), .rd_eof(a_rd_eof),
        .overflow(a_overflow), .drop_count(a_drop_count), .fill_level(a_fill_level)
    );

    neural_stream_packer #(.IN_W(16), .PACK(4), .DEPTH(8)) u_dut_b (
        .bus_clk(clk), .reset_n(reset_n), .in_data(b_in_data), .in_wen(b_in_wen),
        .in_sof(b_in_sof), .stop(b_stop), .rd_open(b_rd_open), .rd_rden(b_rd_rden),
        .rd_data(b_rd_data), .rd_empty(b_rd_empty), .rd_eof(b_rd_eof),
        .overflow(b_overflow), .drop_count(b_drop_count), .fill_level(b_fill_level)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_word(input logic [15:0] d, input logic sof);
        a_in_data = d; a_in_wen = 1'b1; a_in_sof = sof;
        tick();
        a_in_wen = 1'b0; a_in_sof = 1'b0;
    endtask

    task automatic b_word(input logic [15:0] d, input logic sof);
        b_in_data = d; b_in_wen = 1'b1; b_in_sof = sof;
        tick();
        b_in_wen = 1'b0; b_in_sof = 1'b0;
    endtask

    task automatic a_pop();
        a_rd_rden = 1'b1;
        tick();
        a_rd_rden = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        checks++; if (a_rd_empty !== 1'b1) begin failures++; $display("FAIL reset_empty: got %b expected 1", a_rd_empty); end
        checks++; if (a_rd_eof !== 1'b0) begin failures++; $display("FAIL reset_eof: got %b expected 0", a_rd_eof); end
        checks++; if (a_overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", a_overflow); end
        checks++; if (a_drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop: got %0d expected 0", a_drop_count); end
        checks++; if (a_fill_level !== 3'd0) begin failures++; $display("FAIL reset_fill: got %0d expected 0", a_fill_level); end
        checks++; if (a_rd_data !== 32'd0) begin failures++; $display("FAIL reset_rd_data: got %h expected 0", a_rd_data); end
        checks++; if (b_rd_empty !== 1'b1) begin failures++; $display("FAIL reset_b_empty: got %b expected 1", b_rd_empty); end
        reset_n = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_pack();
        logic [31:0] exp;
        a_rd_open = 1'b1;
        tick();
        a_word(16'h5555, 1'b0);
        checks++; if (a_fill_level !== 3'd0) begin failures++; $display("FAIL idle_discard: fill got %0d expected 0", a_fill_level); end
        a_word(16'h1111, 1'b1);
        checks++; if (a_fill_level !== 3'd0) begin failures++; $display("FAIL pack_half: fill got %0d expected 0", a_fill_level); end
        a_word(16'h2222, 1'b0);
        qa.push_back(32'h2222_1111);
        checks++; if (a_fill_level !== 3'd1) begin failures++; $display("FAIL pack_fill: got %0d expected 1", a_fill_level); end
        checks++; if (a_rd_empty !== 1'b0) begin failures++; $display("FAIL pack_empty: got %b expected 0", a_rd_empty); end
        a_pop();
        exp = (qa.size() > 0) ? qa.pop_front() : 32'hDEAD_BEEF;
        checks++; if (a_rd_data !== exp) begin failures++; $display("FAIL pack_data: got %h expected %h", a_rd_data, exp); end
        checks++; if (a_rd_empty !== 1'b1) begin failures++; $display("FAIL pack_empty_after: got %b expected 1", a_rd_empty); end
    endtask

    task automatic test_pad();
        logic [63:0] exp;
        b_rd_open = 1'b1;
        tick();
        b_word(16'h000A, 1'b1);
        b_word(16'h000B, 1'b0);
        b_word(16'h000C, 1'b1);
        qb.push_back(64'h0000_0000_000B_000A);
        checks++; if (b_fill_level !== 4'd1) begin failures++; $display("FAIL pad_fill: got %0d expected 1", b_fill_level); end
        b_word(16'h000D, 1'b0);
        b_word(16'h000E, 1'b0);
        b_word(16'h000F, 1'b0);
        qb.push_back(64'h000F_000E_000D_000C);
        checks++; if (b_fill_level !== 4'd2) begin failures++; $display("FAIL pad_fill2: got %0d expected 2", b_fill_level); end
        for (int i = 0; i < 2; i++) begin
            b_rd_rden = 1'b1; tick(); b_rd_rden = 1'b0;
            exp = (qb.size() > 0) ? qb.pop_front() : 64'hDEAD_BEEF;
            checks++; if (b_rd_data !== exp) begin failures++; $display("FAIL pad_data%0d: got %h expected %h", i, b_rd_data, exp); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp;
        logic [15:0] lo, hi;
        for (int i = 0; i < 4; i++) begin
            lo = 16'h1000 + 16'(i); hi = 16'h2000 + 16'(i);
            a_word(lo, 1'b1); a_word(hi, 1'b0);
            qa.push_back({hi, lo});
        end
        checks++; if (a_fill_level !== 3'd4) begin failures++; $display("FAIL ovf_full: fill got %0d expected 4", a_fill_level); end
        checks++; if (a_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b expected 0", a_overflow); end
        a_word(16'h1004, 1'b1); a_word(16'h2004, 1'b0);
        checks++; if (a_overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b expected 1", a_overflow); end
        checks++; if (a_drop_count !== 16'd1) begin failures++; $display("FAIL ovf_drop1: got %0d expected 1", a_drop_count); end
        a_word(16'h1005, 1'b1); a_word(16'h2005, 1'b0);
        checks++; if (a_drop_count !== 16'd2) begin failures++; $display("FAIL ovf_drop2: got %0d expected 2", a_drop_count); end
        checks++; if (a_fill_level !== 3'd4) begin failures++; $display("FAIL ovf_fill_hold: got %0d expected 4", a_fill_level); end
        for (int i = 0; i < 4; i++) begin
            a_pop();
            exp = (qa.size() > 0) ? qa.pop_front() : 32'hDEAD_BEEF;
            checks++; if (a_rd_data !== exp) begin failures++; $display("FAIL ovf_data%0d: got %h expected %h", i, a_rd_data, exp); end
        end
        a_word(16'h1006, 1'b1); a_word(16'h2006, 1'b0);
        qa.push_back(32'h2006_1006);
        checks++; if (a_fill_level !== 3'd1) begin failures++; $display("FAIL ovf_resume: fill got %0d expected 1", a_fill_level); end
        checks++; if (a_overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", a_overflow); end
        a_pop();
        exp = (qa.size() > 0) ? qa.pop_front() : 32'hDEAD_BEEF;
        checks++; if (a_rd_data !== exp) begin failures++; $display("FAIL ovf_resume_data: got %h expected %h", a_rd_data, exp); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        logic [15:0] lo, hi;
        for (int i = 0; i < 4; i++) begin
            lo = 16'h3000 + 16'(i); hi = 16'h4000 + 16'(i);
            a_word(lo, 1'b1); a_word(hi, 1'b0);
            qa.push_back({hi, lo});
        end
        a_word(16'h3100, 1'b1);
        a_in_data = 16'h4100; a_in_wen = 1'b1; a_rd_rden = 1'b1;
        tick();
        a_in_wen = 1'b0; a_rd_rden = 1'b0;
        exp = (qa.size() > 0) ? qa.pop_front() : 32'hDEAD_BEEF;
        qa.push_back(32'h4100_3100);
        checks++; if (a_rd_data !== exp) begin failures++; $display("FAIL b2b_data: got %h expected %h", a_rd_data, exp); end
        checks++; if (a_fill_level !== 3'd4) begin failures++; $display("FAIL b2b_fill: got %0d expected 4", a_fill_level); end
        checks++; if (a_drop_count !== 16'd2) begin failures++; $display("FAIL b2b_drop: got %0d expected 2", a_drop_count); end
        for (int i = 0; i < 4; i++) begin
            a_pop();
            exp = (qa.size() > 0) ? qa.pop_front() : 32'hDEAD_BEEF;
            checks++; if (a_rd_data !== exp) begin failures++; $display("FAIL b2b_order%0d: got %h expected %h", i, a_rd_data, exp); end
        end
        checks++; if (a_fill_level !== 3'd0) begin failures++; $display("FAIL b2b_final_fill: got %0d expected 0", a_fill_level); end
    endtask

    task automatic test_drain();
        logic [31:0] exp;
        a_word(16'h5000, 1'b1); a_word(16'h5001, 1'b0); qa.push_back(32'h5001_5000);
        a_word(16'h5010, 1'b1); a_word(16'h5011, 1'b0); qa.push_back(32'h5011_5010);
        a_word(16'h5100, 1'b1);
        a_stop = 1'b1; tick(); a_stop = 1'b0;
        qa.push_back(32'h0000_5100);
        checks++; if (a_fill_level !== 3'd3) begin failures++; $display("FAIL drain_fill: got %0d expected 3", a_fill_level); end
        a_word(16'h7777, 1'b1);
        checks++; if (a_fill_level !== 3'd3) begin failures++; $display("FAIL drain_ignore: fill got %0d expected 3", a_fill_level); end
        checks++; if (a_rd_eof !== 1'b0) begin failures++; $display("FAIL drain_eof_early: got %b expected 0", a_rd_eof); end
        for (int i = 0; i < 3; i++) begin
            a_pop();
            exp = (qa.size() > 0) ? qa.pop_front() : 32'hDEAD_BEEF;
            checks++; if (a_rd_data !== exp) begin failures++; $display("FAIL drain_data%0d: got %h expected %h", i, a_rd_data, exp); end
        end
        tick();
        checks++; if (a_rd_eof !== 1'b1) begin failures++; $display("FAIL drain_eof: got %b expected 1", a_rd_eof); end
        checks++; if (a_rd_empty !== 1'b1) begin failures++; $display("FAIL drain_empty: got %b expected 1", a_rd_empty); end
        a_pop();
        checks++; if (a_fill_level !== 3'd0) begin failures++; $display("FAIL empty_read: fill got %0d expected 0", a_fill_level); end
        a_rd_open = 1'b0; tick();
        checks++; if (a_rd_eof !== 1'b0) begin failures++; $display("FAIL close_eof: got %b expected 0", a_rd_eof); end
        checks++; if (a_overflow !== 1'b0) begin failures++; $display("FAIL close_overflow: got %b expected 0", a_overflow); end
        checks++; if (a_drop_count !== 16'd2) begin failures++; $display("FAIL close_drop: got %0d expected 2", a_drop_count); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        a_rd_open = 1'b1; tick();
        a_word(16'h6000, 1'b1); a_word(16'h6001, 1'b0); qa.push_back(32'h6001_6000);
        a_pop();
        exp = (qa.size() > 0) ? qa.pop_front() : 32'hDEAD_BEEF;
        checks++; if (a_rd_data !== exp) begin failures++; $display("FAIL mid_pre_data: got %h expected %h", a_rd_data, exp); end
        a_word(16'h6100, 1'b1); a_word(16'h6101, 1'b0);
        a_word(16'h6200, 1'b1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        qa.delete();
        checks++; if (a_fill_level !== 3'd0) begin failures++; $display("FAIL mid_fill: got %0d expected 0", a_fill_level); end
        checks++; if (a_rd_empty !== 1'b1) begin failures++; $display("FAIL mid_empty: got %b expected 1", a_rd_empty); end
        checks++; if (a_drop_count !== 16'd0) begin failures++; $display("FAIL mid_drop: got %0d expected 0", a_drop_count); end
        checks++; if (a_rd_data !== 32'd0) begin failures++; $display("FAIL mid_rd_data: got %h expected 0", a_rd_data); end
        checks++; if (a_rd_eof !== 1'b0) begin failures++; $display("FAIL mid_eof: got %b expected 0", a_rd_eof); end
        checks++; if (b_fill_level !== 4'd0) begin failures++; $display("FAIL mid_b_fill: got %0d expected 0", b_fill_level); end
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        a_word(16'h6300, 1'b0);
        a_word(16'h6400, 1'b1); a_word(16'h6401, 1'b0); qa.push_back(32'h6401_6400);
        checks++; if (a_fill_level !== 3'd1) begin failures++; $display("FAIL post_fill: got %0d expected 1", a_fill_level); end
        a_pop();
        exp = (qa.size() > 0) ? qa.pop_front() : 32'hDEAD_BEEF;
        checks++; if (a_rd_data !== exp) begin failures++; $display("FAIL post_data: got %h expected %h", a_rd_data, exp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        a_in_data = '0; a_in_wen = 1'b0; a_in_sof = 1'b0; a_stop = 1'b0; a_rd_open = 1'b0; a_rd_rden = 1'b0;
        b_in_data = '0; b_in_wen = 1'b0; b_in_sof = 1'b0; b_stop = 1'b0; b_rd_open = 1'b0; b_rd_rden = 1'b0;
        test_reset();
        test_pack();
        test_pad();
        test_overflow();
        test_back_to_back();
        test_drain();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
